// File: rtl/twos_comp_pkg.sv
// rtl/twos_comp_pkg.sv - shared mode and state types for the serial sign converter
package twos_comp_pkg;

    typedef enum logic [1:0] {
        MODE_NEG   = 2'd0,
        MODE_SM2TC = 2'd1,
        MODE_TC2SM = 2'd2,
        MODE_ABS   = 2'd3
    } conv_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } conv_state_t;

endpackage

// File: rtl/ha_cell.sv
// rtl/ha_cell.sv - half-adder cell reused once per bit by the serial converter
module ha_cell (
    input  logic ai,
    input  logic bi,
    output logic si,
    output logic couti
);

    assign si    = ai ^ bi;
    assign couti = ai & bi;

endmodule

// File: rtl/twos_comp_serial.sv
// rtl/twos_comp_serial.sv - bit-serial NEG / SM2TC / TC2SM / ABS converter, LSB first
module twos_comp_serial
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] a_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] b_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH);

    conv_state_t      state, state_nx;
    conv_mode_t       mode_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_full;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             inv;
    logic             sign;
    logic             nz;
    logic             accept;
    logic             last;
    logic             x;
    logic             sum;
    logic             cout;
    logic             msb_bit;
    logic             res_bit;
    logic             ovf_nx;
    logic             inv_start;

    assign accept    = (state == ST_IDLE) && start_i;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign x         = a_sh[0] ^ inv;
    assign inv_start = (mode_i == MODE_NEG) ? 1'b1 : a_i[WIDTH-1];
    assign busy_o    = (state == ST_RUN);

    ha_cell u_ha (
        .ai    (x),
        .bi    (carry),
        .si    (sum),
        .couti (cout)
    );

    // The sign-magnitude modes replace the serial MSB; nz holds the OR of bits 0..WIDTH-2
    always_comb begin
        msb_bit = sum;
        case (mode_q)
            MODE_SM2TC: msb_bit = sign & nz;
            MODE_TC2SM: msb_bit = sign;
            default:    msb_bit = sum;
        endcase
    end

    assign res_bit  = last ? msb_bit : sum;
    assign res_full = {res_bit, res_sh};
    assign ovf_nx   = (mode_q != MODE_SM2TC) && sign && !nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_i) state_nx = ST_RUN;
            ST_RUN:  if (last)    state_nx = ST_IDLE;
            default:              state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_NEG;
            a_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            inv    <= 1'b0;
            sign   <= 1'b0;
            nz     <= 1'b0;
            done_o <= 1'b0;
            b_o    <= '0;
            ovf_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                a_sh   <= a_i;
                mode_q <= conv_mode_t'(mode_i);
                inv    <= inv_start;
                carry  <= inv_start;
                sign   <= a_i[WIDTH-1];
                nz     <= 1'b0;
                cnt    <= '0;
            end else if (state == ST_RUN) begin
                a_sh   <= a_sh >> 1;
                carry  <= cout;
                nz     <= nz | a_sh[0];
                cnt    <= cnt + 1'b1;
                res_sh <= res_full[WIDTH-1:1];
                if (last) begin
                    b_o    <= res_full;
                    ovf_o  <= ovf_nx;
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_twos_comp_serial.sv
// tb/tb_twos_comp_serial.sv - directed self-checking bench for twos_comp_serial
module tb_twos_comp_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [1:0]  mode8 = 2'd0;
    logic [7:0]  a8 = 8'h00;
    logic        busy8, done8, ovf8;
    logic [7:0]  b8;
    logic        start16 = 1'b0;
    logic [1:0]  mode16 = 2'd0;
    logic [15:0] a16 = 16'h0000;
    logic        busy16, done16, ovf16;
    logic [15:0] b16;

    int total = 0;
    int passed = 0;
    int lat;
    int busy_cnt;
    int gap;
    int seen;
    logic b_stable;

    twos_comp_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .mode_i(mode8), .a_i(a8),
        .busy_o(busy8), .done_o(done8), .b_o(b8), .ovf_o(ovf8)
    );

    twos_comp_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start_i(start16), .mode_i(mode16), .a_i(a16),
        .busy_o(busy16), .done_o(done16), .b_o(b16), .ovf_o(ovf16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run8(input logic [1:0] m, input logic [7:0] a, output int l, output int bc);
        @(negedge clk);
        start8 = 1'b1; mode8 = m; a8 = a;
        @(posedge clk); #1;
        start8 = 1'b0; mode8 = 2'($urandom); a8 = 8'($urandom);
        l = 0; bc = 0;
        while (!done8 && l < 40) begin
            if (busy8) bc++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic conv8(input string tag, input logic [1:0] m, input logic [7:0] a,
                         input logic [7:0] exp_b, input logic exp_ovf);
        int l, bc;
        run8(m, a, l, bc);
        check({tag, "_lat"}, 16'(l), 16'd8);
        check({tag, "_b"}, 16'(b8), 16'(exp_b));
        check({tag, "_ovf"}, 16'(ovf8), 16'(exp_ovf));
    endtask

    initial begin
        #12;
        check("rst_busy", 16'(busy8), 16'd0);
        check("rst_done", 16'(done8), 16'd0);
        check("rst_b", 16'(b8), 16'd0);
        check("rst_ovf", 16'(ovf8), 16'd0);
        @(negedge clk); rst = 1'b0;

        // NEG 05 with handshake timing
        run8(2'd0, 8'h05, lat, busy_cnt);
        check("neg05_lat", 16'(lat), 16'd8);
        check("neg05_busy_cycles", 16'(busy_cnt), 16'd8);
        check("neg05_busy_at_done", 16'(busy8), 16'd0);
        check("neg05_b", 16'(b8), 16'hFB);
        check("neg05_ovf", 16'(ovf8), 16'd0);
        @(posedge clk); #1;
        check("neg05_done_one_cycle", 16'(done8), 16'd0);

        conv8("neg80",   2'd0, 8'h80, 8'h80, 1'b1);
        conv8("sm85",    2'd1, 8'h85, 8'hFB, 1'b0);
        conv8("sm05",    2'd1, 8'h05, 8'h05, 1'b0);
        conv8("sm80",    2'd1, 8'h80, 8'h00, 1'b0);
        conv8("tcFB",    2'd2, 8'hFB, 8'h85, 1'b0);
        conv8("tc7F",    2'd2, 8'h7F, 8'h7F, 1'b0);
        conv8("tc80",    2'd2, 8'h80, 8'h80, 1'b1);
        conv8("abs9C",   2'd3, 8'h9C, 8'h64, 1'b0);
        conv8("abs00",   2'd3, 8'h00, 8'h00, 1'b0);
        conv8("abs80",   2'd3, 8'h80, 8'h80, 1'b1);

        // start during RUN is ignored
        @(negedge clk);
        start8 = 1'b1; mode8 = 2'd0; a8 = 8'h05;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start8 = 1'b1; mode8 = 2'd3; a8 = 8'h9C;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ign_done_seen", 16'(done8), 16'd1);
        check("ign_b", 16'(b8), 16'hFB);
        @(posedge clk); #1;
        check("ign_no_extra_busy", 16'(busy8), 16'd0);

        // back-to-back with start held through done
        @(negedge clk);
        start8 = 1'b1; mode8 = 2'd0; a8 = 8'h05;
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        check("b2b_first_b", 16'(b8), 16'hFB);
        a8 = 8'h03;
        gap = 0; b_stable = 1'b1;
        do begin
            @(posedge clk); #1;
            gap++;
            if (!done8 && b8 !== 8'hFB) b_stable = 1'b0;
        end while (!done8 && gap < 40);
        start8 = 1'b0;
        check("b2b_gap", 16'(gap), 16'd9);
        check("b2b_b_stable", 16'(b_stable), 16'd1);
        check("b2b_second_b", 16'(b8), 16'hFD);

        // asynchronous reset at bit 4
        @(negedge clk);
        start8 = 1'b1; mode8 = 2'd2; a8 = 8'hFB;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 16'(busy8), 16'd0);
        check("abort_done", 16'(done8), 16'd0);
        check("abort_b", 16'(b8), 16'd0);
        check("abort_ovf", 16'(ovf8), 16'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done8) seen++; end
        check("abort_no_done", 16'(seen), 16'd0);
        conv8("after_abort_abs9C", 2'd3, 8'h9C, 8'h64, 1'b0);

        // WIDTH=16
        @(negedge clk);
        start16 = 1'b1; mode16 = 2'd0; a16 = 16'h0001;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'h1234;
        lat = 0;
        while (!done16 && lat < 60) begin @(posedge clk); #1; lat++; end
        check("w16_lat", 16'(lat), 16'd16);
        check("w16_b", b16, 16'hFFFF);
        check("w16_ovf", 16'(ovf16), 16'd0);
        @(negedge clk);
        start16 = 1'b1; mode16 = 2'd1; a16 = 16'h8003;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 60) begin @(posedge clk); #1; lat++; end
        check("w16_sm_b", b16, 16'hFFFD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
